// File: rtl/sha256_msg_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_msg_sched_if : block-load and schedule-output bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface sha256_msg_sched_if;
  logic        start;
  logic [31:0] blk_word;
  logic        blk_valid;
  logic        blk_ready;
  logic        en;
  logic [31:0] wt;
  logic        wt_valid;
  logic [5:0]  r_cntr;
  logic        done;

  modport master (
    output start, blk_word, blk_valid, en,
    input  blk_ready, wt, wt_valid, r_cntr, done
  );

  modport slave (
    input  start, blk_word, blk_valid, en,
    output blk_ready, wt, wt_valid, r_cntr, done
  );
endinterface
`default_nettype wire

// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_msg_sched : SHA-256 message schedule, loads W0..W15, expands W16..W63
// Rev 1.0
// ---------------------------------------------------------------------------
module sha256_msg_sched #(
  parameter logic [3:0] CORE = 4'b0
) (
  input wire                clk,
  input wire                rst,
  sha256_msg_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] c_last_load  = 6'd15;
  localparam logic [5:0] c_last_round = 6'd63;

  state_t      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] buf_q [16];
  logic [31:0] buf_d [16];
  logic [31:0] wt_q, wt_d;
  logic [5:0]  r_cntr_q, r_cntr_d;
  logic        wt_valid_q, wt_valid_d;
  logic        done_q, done_d;
  logic        blk_ready_q, blk_ready_d;

  logic [3:0]  w_slot;
  logic [3:0]  w_m2;
  logic [3:0]  w_m7;
  logic [3:0]  w_m15;
  logic [31:0] w_next;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // The 16-deep window is circular: slot t mod 16 still holds W[t-16]
  // when W[t] is computed, so it is read and then overwritten in one edge.
  assign w_slot = t_q[3:0];
  assign w_m2   = w_slot - 4'd2;
  assign w_m7   = w_slot - 4'd7;
  assign w_m15  = w_slot - 4'd15;
  assign w_next = ssig1(buf_q[w_m2]) + buf_q[w_m7]
                + ssig0(buf_q[w_m15]) + buf_q[w_slot];

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    buf_d       = buf_q;
    wt_d        = wt_q;
    r_cntr_d    = r_cntr_q;
    wt_valid_d  = 1'b0;
    done_d      = 1'b0;
    blk_ready_d = blk_ready_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = LOAD;
          t_d         = '0;
          blk_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (bus.blk_valid) begin
          buf_d[w_slot] = bus.blk_word;
          wt_d          = bus.blk_word;
          r_cntr_d      = t_q;
          wt_valid_d    = 1'b1;
          t_d           = t_q + 6'd1;
          if (t_q == c_last_load) begin
            state_d     = RUN;
            blk_ready_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (bus.en) begin
          buf_d[w_slot] = w_next;
          wt_d          = w_next;
          r_cntr_d      = t_q;
          wt_valid_d    = 1'b1;
          // t parks at 63 rather than wrapping; IDLE clears it on start.
          if (t_q == c_last_round) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      wt_q        <= '0;
      r_cntr_q    <= '0;
      wt_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      blk_ready_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      wt_q        <= wt_d;
      r_cntr_q    <= r_cntr_d;
      wt_valid_q  <= wt_valid_d;
      done_q      <= done_d;
      blk_ready_q <= blk_ready_d;
      buf_q       <= buf_d;
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.wt        = wt_q;
  assign bus.wt_valid  = wt_valid_q;
  assign bus.r_cntr    = r_cntr_q;
  assign bus.done      = done_q;

  // CORE only tags the instance; the branch label shows it in the hierarchy.
  if (CORE == 4'b0) begin : g_core_default
  end else begin : g_core_tagged
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha256_msg_sched : randomized self-checking bench for sha256_msg_sched
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;

  sha256_msg_sched_if bus ();

  sha256_msg_sched #(.CORE(4'h3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Observation log: every wt_valid beat with its round index and cycle.
  logic [31:0] obs_w [$];
  int          obs_r [$];
  int          obs_c [$];

  always @(negedge clk) begin
    if (bus.wt_valid === 1'b1) begin
      obs_w.push_back(bus.wt);
      obs_r.push_back(int'(bus.r_cntr));
      obs_c.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  // Reference model: textbook 64-entry schedule expansion.
  logic [31:0] cur_blk [16];
  logic [31:0] exp_w   [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sg0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sg1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic model_block();
    for (int t = 0; t < 16; t++) exp_w[t] = cur_blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = sg1(exp_w[t-2]) + exp_w[t-7] + sg0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
    model_block();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom();
    model_block();
  endtask

  // Stimulus only: start pulse then 16 words, optionally with 2-cycle gaps.
  task automatic load_block(input bit gappy, input bit start_with_valid);
    @(negedge clk);
    bus.start = 1'b1;
    if (start_with_valid) begin
      bus.blk_valid = 1'b1;
      bus.blk_word  = 32'hDEADBEEF;
    end
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.blk_valid = 1'b1;
      bus.blk_word  = cur_blk[i];
      @(negedge clk);
      if (gappy) begin
        bus.blk_valid = 1'b0;
        bus.blk_word  = $urandom();
        repeat (2) @(negedge clk);
      end
    end
    bus.blk_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok       = 1'b1;
        done_cyc = cyc;
      end
    end
    #1;
  endtask

  task automatic wait_round(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.wt_valid === 1'b1 && int'(bus.r_cntr) == r) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.wt !== 32'h0) $display("FAIL rst_wt: got %08h want 0", bus.wt); else n_pass++;
    n_checks++; if (bus.r_cntr !== 6'd0) $display("FAIL rst_r_cntr: got %0d want 0", bus.r_cntr); else n_pass++;
    n_checks++; if (bus.wt_valid !== 1'b0) $display("FAIL rst_wt_valid: got %b want 0", bus.wt_valid); else n_pass++;
    n_checks++; if (bus.blk_ready !== 1'b0) $display("FAIL rst_blk_ready: got %b want 0", bus.blk_ready); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else n_pass++;
    rst = 1'b0;
    // Without start, IDLE must neither be ready nor take words.
    bus.blk_valid = 1'b1;
    bus.blk_word  = 32'h12345678;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.blk_ready !== 1'b0) $display("FAIL idle_blk_ready: got %b want 0", bus.blk_ready); else n_pass++;
    n_checks++; if (obs_w.size() != 0) $display("FAIL idle_accept: got %0d beats want 0", obs_w.size()); else n_pass++;
    bus.blk_valid = 1'b0;
  endtask

  task automatic test_abc();
    bit ok;
    int d0;
    set_abc();
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    d0 = done_cnt;
    load_block(1'b0, 1'b0);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL abc_done_timeout: got no done want done"); else n_pass++;
    n_checks++; if (obs_w.size() != 64) $display("FAIL abc_count: got %0d want 64", obs_w.size()); else n_pass++;
    if (obs_w.size() >= 18) begin
      n_checks++; if (obs_r[16] != 16 || obs_w[16] !== 32'h61626380)
        $display("FAIL abc_w16: got r=%0d wt=%08h want r=16 wt=61626380", obs_r[16], obs_w[16]); else n_pass++;
      n_checks++; if (obs_r[17] != 17 || obs_w[17] !== 32'h000F0000)
        $display("FAIL abc_w17: got r=%0d wt=%08h want r=17 wt=000f0000", obs_r[17], obs_w[17]); else n_pass++;
    end
    for (int i = 0; i < 64 && i < obs_w.size(); i++) begin
      n_checks++;
      if (obs_r[i] != i || obs_w[i] !== exp_w[i])
        $display("FAIL abc_w%0d: got r=%0d wt=%08h want r=%0d wt=%08h", i, obs_r[i], obs_w[i], i, exp_w[i]);
      else n_pass++;
    end
    if (obs_c.size() == 64) begin
      n_checks++; if (obs_c[63] - obs_c[0] != 63)
        $display("FAIL abc_throughput: got span %0d want 63", obs_c[63] - obs_c[0]); else n_pass++;
    end
    n_checks++; if (done_cnt != d0 + 1) $display("FAIL abc_done_count: got %0d want %0d", done_cnt - d0, 1); else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    set_random();
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    load_block(1'b0, 1'b0);
    wait_round(30, ok);
    n_checks++; if (!ok) $display("FAIL stall_find30: got none want r_cntr=30"); else n_pass++;
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.wt_valid !== 1'b0) $display("FAIL stall_valid%0d: got %b want 0", k, bus.wt_valid); else n_pass++;
      n_checks++; if (bus.r_cntr !== 6'd30 || bus.wt !== exp_w[30])
        $display("FAIL stall_hold%0d: got r=%0d wt=%08h want r=30 wt=%08h", k, bus.r_cntr, bus.wt, exp_w[30]); else n_pass++;
    end
    bus.en = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.wt_valid !== 1'b1 || bus.r_cntr !== 6'd31 || bus.wt !== exp_w[31])
      $display("FAIL stall_resume: got v=%b r=%0d wt=%08h want v=1 r=31 wt=%08h",
               bus.wt_valid, bus.r_cntr, bus.wt, exp_w[31]); else n_pass++;
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL stall_done_timeout: got no done want done"); else n_pass++;
    n_checks++; if (obs_w.size() != 64) $display("FAIL stall_count: got %0d want 64", obs_w.size()); else n_pass++;
    for (int i = 0; i < 64 && i < obs_w.size(); i++) begin
      n_checks++;
      if (obs_r[i] != i || obs_w[i] !== exp_w[i])
        $display("FAIL stall_w%0d: got r=%0d wt=%08h want r=%0d wt=%08h", i, obs_r[i], obs_w[i], i, exp_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_load_gaps();
    bit ok;
    int n_load;
    set_random();
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    load_block(1'b1, 1'b1);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL gaps_done_timeout: got no done want done"); else n_pass++;
    n_load = 0;
    foreach (obs_r[i]) if (obs_r[i] < 16 && i < 16) n_load++;
    n_checks++; if (n_load != 16) $display("FAIL gaps_load_count: got %0d want 16", n_load); else n_pass++;
    n_checks++; if (obs_w.size() != 64) $display("FAIL gaps_count: got %0d want 64", obs_w.size()); else n_pass++;
    for (int i = 0; i < 64 && i < obs_w.size(); i++) begin
      n_checks++;
      if (obs_r[i] != i || obs_w[i] !== exp_w[i])
        $display("FAIL gaps_w%0d: got r=%0d wt=%08h want r=%0d wt=%08h", i, obs_r[i], obs_w[i], i, exp_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int d0;
    set_abc();
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    d0 = done_cnt;
    load_block(1'b0, 1'b0);
    wait_round(40, ok);
    n_checks++; if (!ok) $display("FAIL mrst_find40: got none want r_cntr=40"); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.wt !== 32'h0 || bus.r_cntr !== 6'd0 || bus.wt_valid !== 1'b0 ||
                    bus.blk_ready !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mrst_outputs: got wt=%08h r=%0d v=%b rdy=%b done=%b want all 0",
               bus.wt, bus.r_cntr, bus.wt_valid, bus.blk_ready, bus.done); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (done_cnt != d0) $display("FAIL mrst_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
    n_checks++; if (bus.wt_valid !== 1'b0 || bus.blk_ready !== 1'b0)
      $display("FAIL mrst_needs_start: got v=%b rdy=%b want 0 0", bus.wt_valid, bus.blk_ready); else n_pass++;
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    load_block(1'b0, 1'b0);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL mrst_done_timeout: got no done want done"); else n_pass++;
    n_checks++; if (obs_w.size() != 64) $display("FAIL mrst_count: got %0d want 64", obs_w.size()); else n_pass++;
    for (int i = 0; i < 64 && i < obs_w.size(); i++) begin
      n_checks++;
      if (obs_r[i] != i || obs_w[i] !== exp_w[i])
        $display("FAIL mrst_w%0d: got r=%0d wt=%08h want r=%0d wt=%08h", i, obs_r[i], obs_w[i], i, exp_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_start_in_run_and_done();
    bit ok;
    int d0;
    set_random();
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    d0 = done_cnt;
    load_block(1'b0, 1'b0);
    wait_round(20, ok);
    n_checks++; if (!ok) $display("FAIL srun_find20: got none want r_cntr=20"); else n_pass++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL srun_done_timeout: got no done want done"); else n_pass++;
    n_checks++; if (obs_w.size() != 64) $display("FAIL srun_count: got %0d want 64", obs_w.size()); else n_pass++;
    for (int i = 0; i < 64 && i < obs_w.size(); i++) begin
      n_checks++;
      if (obs_r[i] != i || obs_w[i] !== exp_w[i])
        $display("FAIL srun_w%0d: got r=%0d wt=%08h want r=%0d wt=%08h", i, obs_r[i], obs_w[i], i, exp_w[i]);
      else n_pass++;
    end
    if (obs_c.size() == 64) begin
      n_checks++; if (done_cyc != obs_c[63])
        $display("FAIL srun_done_timing: got cycle %0d want %0d", done_cyc, obs_c[63]); else n_pass++;
    end
    // Next cycles are IDLE: no pulses, not ready, last word retained.
    bus.blk_valid = 1'b1;
    bus.blk_word  = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0 || bus.blk_ready !== 1'b0 || bus.wt_valid !== 1'b0)
        $display("FAIL srun_idle%0d: got done=%b rdy=%b v=%b want 0 0 0", k, bus.done, bus.blk_ready, bus.wt_valid);
      else n_pass++;
      n_checks++; if (bus.r_cntr !== 6'd63 || bus.wt !== exp_w[63])
        $display("FAIL srun_retain%0d: got r=%0d wt=%08h want r=63 wt=%08h", k, bus.r_cntr, bus.wt, exp_w[63]);
      else n_pass++;
    end
    bus.blk_valid = 1'b0;
    n_checks++; if (done_cnt != d0 + 1) $display("FAIL srun_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int dcyc;
    set_random();
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    load_block(1'b0, 1'b0);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL b2b_a_done_timeout: got no done want done"); else n_pass++;
    n_checks++; if (obs_w.size() != 64 || obs_w[obs_w.size()-1] !== exp_w[63])
      $display("FAIL b2b_a_last: got %0d beats want 64 ending %08h", obs_w.size(), exp_w[63]); else n_pass++;
    dcyc = done_cyc;
    obs_w.delete(); obs_r.delete(); obs_c.delete();
    set_random();
    load_block(1'b0, 1'b0);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL b2b_b_done_timeout: got no done want done"); else n_pass++;
    if (obs_w.size() > 0) begin
      n_checks++; if (obs_r[0] != 0 || obs_w[0] !== cur_blk[0])
        $display("FAIL b2b_b_w0: got r=%0d wt=%08h want r=0 wt=%08h", obs_r[0], obs_w[0], cur_blk[0]); else n_pass++;
      n_checks++; if (obs_c[0] != dcyc + 3)
        $display("FAIL b2b_b_w0_cycle: got %0d want %0d", obs_c[0], dcyc + 3); else n_pass++;
    end
    n_checks++; if (obs_w.size() != 64) $display("FAIL b2b_b_count: got %0d want 64", obs_w.size()); else n_pass++;
    for (int i = 0; i < 64 && i < obs_w.size(); i++) begin
      n_checks++;
      if (obs_r[i] != i || obs_w[i] !== exp_w[i])
        $display("FAIL b2b_b_w%0d: got r=%0d wt=%08h want r=%0d wt=%08h", i, obs_r[i], obs_w[i], i, exp_w[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_word  = 32'h0;
    bus.en        = 1'b1;
    test_reset();
    test_abc();
    test_stall();
    test_load_gaps();
    test_reset_mid_run();
    test_start_in_run_and_done();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit want normal end");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
